program_loader: RTL and testbench

// - Upstream feeder of the cache unit's I/O write port: receives a framed byte stream (UART/debug host)

---
 rtl/program_loader.sv | 140 ++++++++++++++
 tb/tb_program_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: turns a framed byte stream into little-endian 32-bit cache writes.
// Latency: each word's write strobe appears the cycle after its 4th byte is accepted;
//   op_wr_done appears the cycle after a good checksum byte.
// Backpressure: op_byte_ready is high only while a frame is open (LEN/DATA/CHK); the
//   cache side never stalls, so writes are strobed without a handshake.
// Frame: LEN (4 bytes, LE word count N) | N*4 payload bytes | CHK (XOR of all earlier bytes).
// Ports:
//   ip_clk, ip_rst        clock (rising edge), asynchronous active-high reset
//   ip_load_req           cache wants a program; dropping it mid-frame aborts the frame
//   ip_byte/ip_byte_valid stream input; accepted when ip_byte_valid & op_byte_ready
//   op_byte_ready         loader can take a byte this cycle
//   op_wr_addr/data/en    one-cycle word write to the cache, address BASE_ADDR + 4*k
//   op_wr_done            one-cycle pulse: frame complete, checksum good
//   op_busy               frame in progress
//   op_error              sticky length/checksum error, cleared only by reset
module program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] MAX_WORDS = 32'h0000_2000
) (
  input  logic        ip_clk,
  input  logic        ip_rst,
  input  logic        ip_load_req,
  input  logic [7:0]  ip_byte,
  input  logic        ip_byte_valid,
  output logic        op_byte_ready,
  output logic [31:0] op_wr_addr,
  output logic [31:0] op_wr_data,
  output logic        op_wr_en,
  output logic        op_wr_done,
  output logic        op_busy,
  output logic        op_error
);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CHK, S_DONE, S_ERR} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_active;     // drives both op_byte_ready and op_busy
  logic [1:0]  r_byte_cnt;   // byte position within the current LE word
  logic [23:0] r_shift;      // first three bytes of the word being assembled
  logic [31:0] r_len;
  logic [31:0] r_word_idx;
  logic [7:0]  r_chk;
  logic [31:0] r_wr_addr;
  logic [31:0] r_wr_data;
  logic        r_wr_en;
  logic        r_done;
  logic        r_error;

  logic        w_take;
  logic        w_last_byte;
  logic        w_last_word;
  logic [31:0] w_full;

  // A byte that arrives on the same edge as an abort is dropped, so it can
  // never schedule a write for a frame that is being abandoned.
  assign w_take      = ip_byte_valid & r_active & ip_load_req;
  assign w_last_byte = (r_byte_cnt == 2'd3);
  assign w_full      = {ip_byte, r_shift};
  assign w_last_word = (r_word_idx == r_len - 32'd1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (ip_load_req) w_next = S_LEN;
      S_LEN: begin
        if (!ip_load_req) w_next = S_IDLE;
        else if (w_take && w_last_byte) begin
          if (w_full > MAX_WORDS)   w_next = S_ERR;
          else if (w_full == 32'd0) w_next = S_CHK;
          else                      w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (!ip_load_req) w_next = S_IDLE;
        else if (w_take && w_last_byte && w_last_word) w_next = S_CHK;
      end
      S_CHK: begin
        if (!ip_load_req) w_next = S_IDLE;
        else if (w_take) w_next = (ip_byte == r_chk) ? S_DONE : S_ERR;
      end
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ip_clk or posedge ip_rst) begin
    if (ip_rst) begin
      r_state    <= S_IDLE;
      r_active   <= 1'b0;
      r_byte_cnt <= 2'd0;
      r_shift    <= 24'd0;
      r_len      <= 32'd0;
      r_word_idx <= 32'd0;
      r_chk      <= 8'd0;
      r_wr_addr  <= 32'd0;
      r_wr_data  <= 32'd0;
      r_wr_en    <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_active <= (w_next == S_LEN) || (w_next == S_DATA) || (w_next == S_CHK);
      r_wr_en  <= 1'b0;
      r_done   <= (w_next == S_DONE);
      r_error  <= (w_next == S_ERR);

      if (r_state == S_IDLE && w_next == S_LEN) begin
        r_byte_cnt <= 2'd0;
        r_shift    <= 24'd0;
        r_len      <= 32'd0;
        r_word_idx <= 32'd0;
        r_chk      <= 8'd0;
      end else if (w_take && (r_state == S_LEN || r_state == S_DATA)) begin
        r_chk      <= r_chk ^ ip_byte;
        r_byte_cnt <= r_byte_cnt + 2'd1;
        if (!w_last_byte) begin
          r_shift[8*r_byte_cnt +: 8] <= ip_byte;
        end else if (r_state == S_LEN) begin
          r_len <= w_full;
        end else begin
          r_wr_en    <= 1'b1;
          r_wr_addr  <= BASE_ADDR + {r_word_idx[29:0], 2'b00};
          r_wr_data  <= w_full;
          r_word_idx <= r_word_idx + 32'd1;
        end
      end
    end
  end

  assign op_byte_ready = r_active;
  assign op_busy       = r_active;
  assign op_wr_addr    = r_wr_addr;
  assign op_wr_data    = r_wr_data;
  assign op_wr_en      = r_wr_en;
  assign op_wr_done    = r_done;
  assign op_error      = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a cycle-by-cycle table for one clean N=2 frame,
// then directed sequences for checksum error, length limit, empty frame,
// gapped input, abort and asynchronous reset.
// The reference checksum includes the four LEN bytes, so the N=2 frame
// 02 00 00 00 | 13 00 50 00 | 93 00 10 00 closes with C2.
module tb_program_loader;

  logic        ip_clk = 1'b0;
  logic        ip_rst = 1'b1;
  logic        ip_load_req = 1'b0;
  logic [7:0]  ip_byte = 8'h00;
  logic        ip_byte_valid = 1'b0;
  logic        op_byte_ready;
  logic [31:0] op_wr_addr;
  logic [31:0] op_wr_data;
  logic        op_wr_en;
  logic        op_wr_done;
  logic        op_busy;
  logic        op_error;

  program_loader dut (
    .ip_clk(ip_clk), .ip_rst(ip_rst), .ip_load_req(ip_load_req),
    .ip_byte(ip_byte), .ip_byte_valid(ip_byte_valid), .op_byte_ready(op_byte_ready),
    .op_wr_addr(op_wr_addr), .op_wr_data(op_wr_data), .op_wr_en(op_wr_en),
    .op_wr_done(op_wr_done), .op_busy(op_busy), .op_error(op_error)
  );

  always #5 ip_clk = ~ip_clk;

  // {ready, busy, wr_en, done, error, addr, data}
  logic [68:0] w_outs;
  assign w_outs = {op_byte_ready, op_busy, op_wr_en, op_wr_done, op_error, op_wr_addr, op_wr_data};

  typedef struct {
    logic        lreq;
    logic        vld;
    logic [7:0]  b;
    logic [68:0] exp;
  } vec_t;

  vec_t        tbl[16];
  logic [7:0]  frm[$];
  logic [63:0] wq[$];
  int          done_cnt = 0;
  int          nvec = 0;
  int          errs = 0;

  // Write/done monitor, sampled on the falling edge.
  always @(negedge ip_clk) begin
    if (!ip_rst) begin
      if (op_wr_en)   wq.push_back({op_wr_addr, op_wr_data});
      if (op_wr_done) done_cnt++;
    end
  end

  function automatic vec_t mk(logic lreq, logic vld, logic [7:0] b, logic rdy, logic busy,
                              logic wr, logic done, logic err, logic [31:0] a, logic [31:0] d);
    vec_t v;
    v.lreq = lreq; v.vld = vld; v.b = b;
    v.exp  = {rdy, busy, wr, done, err, a, d};
    return v;
  endfunction

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ip_clk);
    #1;
  endtask

  task automatic do_reset();
    ip_rst = 1'b1; ip_load_req = 1'b0; ip_byte_valid = 1'b0; ip_byte = 8'h00;
    repeat (2) @(posedge ip_clk);
    #1 ip_rst = 1'b0;
    wq.delete();
    done_cnt = 0;
  endtask

  task automatic put(input logic [7:0] b);
    ip_byte_valid = 1'b1; ip_byte = b;
    tick();
    ip_byte_valid = 1'b0;
  endtask

  // Open a frame, stream frm (optionally with a dead cycle before every byte),
  // then drop the request one cycle after the done slot, as the cache does.
  task automatic send_frame(input bit gaps);
    ip_load_req = 1'b1; ip_byte_valid = 1'b0;
    tick();
    foreach (frm[i]) begin
      if (gaps) begin ip_byte_valid = 1'b0; tick(); end
      put(frm[i]);
    end
    tick();
    ip_load_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic check_std_writes(input string tag);
    check({tag, "_nwr"}, 69'(wq.size()), 69'd2);
    if (wq.size() > 0) check({tag, "_wr0"}, 69'(wq[0]), {5'd0, 32'h0000_0000, 32'h0050_0013});
    if (wq.size() > 1) check({tag, "_wr1"}, 69'(wq[1]), {5'd0, 32'h0000_0004, 32'h0010_0093});
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 8'h00, 1, 1, 0, 0, 0, 32'h0, 32'h0);
    tbl[1]  = mk(1, 1, 8'h02, 1, 1, 0, 0, 0, 32'h0, 32'h0);
    tbl[2]  = mk(1, 1, 8'h00, 1, 1, 0, 0, 0, 32'h0, 32'h0);
    tbl[3]  = mk(1, 1, 8'h00, 1, 1, 0, 0, 0, 32'h0, 32'h0);
    tbl[4]  = mk(1, 1, 8'h00, 1, 1, 0, 0, 0, 32'h0, 32'h0);
    tbl[5]  = mk(1, 1, 8'h13, 1, 1, 0, 0, 0, 32'h0, 32'h0);
    tbl[6]  = mk(1, 1, 8'h00, 1, 1, 0, 0, 0, 32'h0, 32'h0);
    tbl[7]  = mk(1, 1, 8'h50, 1, 1, 0, 0, 0, 32'h0, 32'h0);
    tbl[8]  = mk(1, 1, 8'h00, 1, 1, 1, 0, 0, 32'h0, 32'h0050_0013);
    tbl[9]  = mk(1, 1, 8'h93, 1, 1, 0, 0, 0, 32'h0, 32'h0050_0013);
    tbl[10] = mk(1, 1, 8'h00, 1, 1, 0, 0, 0, 32'h0, 32'h0050_0013);
    tbl[11] = mk(1, 1, 8'h10, 1, 1, 0, 0, 0, 32'h0, 32'h0050_0013);
    tbl[12] = mk(1, 1, 8'h00, 1, 1, 1, 0, 0, 32'h4, 32'h0010_0093);
    tbl[13] = mk(1, 1, 8'hC2, 0, 0, 0, 1, 0, 32'h4, 32'h0010_0093);
    tbl[14] = mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 32'h4, 32'h0010_0093);
    tbl[15] = mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 32'h4, 32'h0010_0093);

    // Reset state, while reset is held and just after release.
    #3 check("reset_hold", w_outs, 69'd0);
    do_reset();
    check("reset_release", w_outs, 69'd0);
    tick();
    check("idle_no_req", w_outs, 69'd0);

    // Clean N=2 frame, cycle by cycle.
    for (int i = 0; i < 16; i++) begin
      ip_load_req = tbl[i].lreq; ip_byte_valid = tbl[i].vld; ip_byte = tbl[i].b;
      tick();
      check($sformatf("table_%0d", i), w_outs, tbl[i].exp);
    end
    ip_byte_valid = 1'b0;
    repeat (2) tick();
    check("table_no_restart", 69'(op_busy), 69'd0);
    check("table_done_cnt", 69'(done_cnt), 69'd1);

    // Bad checksum: words still land, error sticks, no done, no more bytes taken.
    do_reset();
    frm = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hC1};
    send_frame(1'b0);
    check_std_writes("badchk");
    check("badchk_done", 69'(done_cnt), 69'd0);
    check("badchk_err", 69'({op_error, op_byte_ready, op_busy}), 69'b100);
    ip_load_req = 1'b1;
    repeat (3) tick();
    check("badchk_sticky", 69'({op_error, op_byte_ready}), 69'b10);

    // Length one above the limit.
    do_reset();
    ip_load_req = 1'b1; tick();
    put(8'h01); put(8'h20); put(8'h00); put(8'h00);
    check("len_over_err", 69'({op_error, op_byte_ready, op_busy}), 69'b100);
    tick();
    check("len_over_nowr", 69'(wq.size()), 69'd0);

    // Length exactly at the limit is accepted into the payload phase.
    do_reset();
    ip_load_req = 1'b1; tick();
    put(8'h00); put(8'h20); put(8'h00); put(8'h00);
    check("len_max_data", 69'({op_error, op_byte_ready, op_busy}), 69'b011);
    ip_load_req = 1'b0; tick();
    check("len_max_abort", 69'({op_error, op_busy}), 69'b00);

    // Empty frame: done pulses for exactly one cycle after the checksum byte.
    do_reset();
    ip_load_req = 1'b1; tick();
    put(8'h00); put(8'h00); put(8'h00); put(8'h00);
    check("empty_chk_state", 69'({op_busy, op_error}), 69'b10);
    put(8'h00);
    check("empty_done_hi", 69'({op_wr_done, op_wr_en, op_error}), 69'b100);
    tick();
    check("empty_done_lo", 69'(op_wr_done), 69'd0);
    ip_load_req = 1'b0; repeat (2) tick();
    check("empty_nowr", 69'(wq.size()), 69'd0);

    // Same N=2 frame with a gap before every byte.
    do_reset();
    frm = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hC2};
    send_frame(1'b1);
    check_std_writes("gaps");
    check("gaps_done", 69'(done_cnt), 69'd1);
    check("gaps_err", 69'(op_error), 69'd0);

    // Request dropped two bytes into the first word, then a full reload.
    do_reset();
    ip_load_req = 1'b1; tick();
    put(8'h02); put(8'h00); put(8'h00); put(8'h00); put(8'h13); put(8'h00);
    ip_load_req = 1'b0; tick();
    check("abort_idle", 69'({op_busy, op_byte_ready, op_error, op_wr_done}), 69'd0);
    repeat (2) tick();
    check("abort_nowr", 69'(wq.size()), 69'd0);
    check("abort_nodone", 69'(done_cnt), 69'd0);
    send_frame(1'b0);
    check_std_writes("reload");
    check("reload_done", 69'(done_cnt), 69'd1);

    // Asynchronous reset in the middle of the second word.
    do_reset();
    ip_load_req = 1'b1; tick();
    put(8'h02); put(8'h00); put(8'h00); put(8'h00);
    put(8'h13); put(8'h00); put(8'h50); put(8'h00); put(8'h93);
    check("prerst_busy", 69'(op_busy), 69'd1);
    #2 ip_rst = 1'b1;
    #1 check("async_rst", w_outs, 69'd0);
    @(posedge ip_clk);
    #1 ip_rst = 1'b0; ip_load_req = 1'b0;
    wq.delete(); done_cnt = 0;
    tick();
    send_frame(1'b0);
    check_std_writes("postrst");
    check("postrst_done", 69'(done_cnt), 69'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
